// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem request, tagged FWFT buffer to decode.
// Optional IF_ALIGN_CHECK_EN: misaligned redirect raises fetch_misaligned and holds fetch.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_t;

  state_t                       r_state, w_state_n;
  logic [31:0]                  r_pc, r_inflight_pc;
  logic [FIFO_DEPTH-1:0][31:0]  r_fdata, r_fpc;
  logic [AW-1:0]                r_wptr, r_rptr;
  logic [CW-1:0]                r_count;
  logic                         w_req_valid, w_req_fire;
  logic                         w_push, w_pop, w_full, w_empty;
  logic                         w_hold;
  logic [31:0]                  w_redir_pc;

`ifdef IF_ALIGN_CHECK_EN
  logic r_misaligned;

  always_ff @(posedge clk) begin
    if (rst)                 r_misaligned <= 1'b0;
    else if (redirect_valid) r_misaligned <= |redirect_pc[1:0];
  end

  assign w_hold           = r_misaligned;
  assign w_redir_pc       = redirect_pc;
  assign fetch_misaligned = r_misaligned && !rst;
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^redirect_pc[1:0];
  assign w_hold       = 1'b0;
  assign w_redir_pc   = {redirect_pc[31:2], 2'b00};
`endif

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  always_comb begin
    w_state_n   = r_state;
    w_req_valid = 1'b0;
    case (r_state)
      S_REQ: begin
        w_req_valid = !w_full && !redirect_valid && !w_hold;
        if (w_req_valid && imem_req_ready) w_state_n = S_WAIT;
      end
      S_WAIT: begin
        // redirect racing the response: the response is the stale one, nothing left to wait for
        if (redirect_valid)      w_state_n = imem_rsp_valid ? S_REQ : S_DISCARD;
        else if (imem_rsp_valid) w_state_n = S_REQ;
      end
      S_DISCARD: begin
        if (imem_rsp_valid) w_state_n = S_REQ;
      end
      default: w_state_n = S_REQ;
    endcase
  end

  assign w_req_fire = w_req_valid && imem_req_ready && !rst;
  assign w_push     = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign w_pop      = !w_empty && instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_inflight_pc <= '0;
    end else begin
      r_state <= w_state_n;
      if (redirect_valid) begin
        r_pc <= w_redir_pc;
      end else if (w_req_fire) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + 32'd4;
      end
    end
  end

  // flush on redirect wins over any pop/push in the same cycle
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fdata[r_wptr] <= imem_rsp_data;
      r_fpc[r_wptr]   <= r_inflight_pc;
    end
  end

  assign imem_req_valid = w_req_valid && !rst;
  assign imem_addr      = rst ? 32'h0 : r_pc;
  assign instr_valid    = !w_empty && !rst;
  assign instr          = rst ? 32'h0 : r_fdata[r_rptr];
  assign instr_pc       = rst ? 32'h0 : r_fpc[r_rptr];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: behavioural imem with variable latency plus a wrap-PC instance.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
`ifdef IF_ALIGN_CHECK_EN
  logic        fetch_misaligned, w_mis;
`endif

  instr_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
`ifdef IF_ALIGN_CHECK_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  // second instance only exercises PC wrap from the top of the address space
  logic        wv, wrv = 1'b0, w_one = 1'b1, w_zero = 1'b0, wiv;
  logic [31:0] wa, wi, wip, w_zd = 32'h0;
  bit          w_seen;

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req_valid(wv), .imem_req_ready(w_one), .imem_addr(wa),
    .imem_rsp_valid(wrv), .imem_rsp_data(w_zd),
    .redirect_valid(w_zero), .redirect_pc(w_zd),
    .instr_valid(wiv), .instr_ready(w_one), .instr(wi), .instr_pc(wip)
`ifdef IF_ALIGN_CHECK_EN
    , .fetch_misaligned(w_mis)
`endif
  );

  int          n_cmp = 0, n_bad = 0;
  int          m_lat = 1, m_cnt;
  bit          m_pend;
  logic [31:0] m_addr;
  logic [63:0] exp_q[$], exp_d[$], obs_q[$];
  logic [31:0] addr_q[$], waddr_q[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'd3 + 32'h1234_5678;
  endfunction

  // imem model + scoreboard capture; runs on negedge so DUT outputs are settled
  always @(negedge clk) begin
    if (rst) begin
      m_pend = 0;
      imem_rsp_valid = 1'b0;
      exp_q.delete();
    end else begin
      if (instr_valid && instr_ready && !redirect_valid) begin
        obs_q.push_back({instr_pc, instr});
        if (exp_q.size() > 0) exp_d.push_back(exp_q.pop_front());
        else                  exp_d.push_back(64'hDEAD_BEEF_DEAD_BEEF);
      end
      if (redirect_valid) exp_q.delete();
      imem_rsp_valid = 1'b0;
      if (m_pend) begin
        m_cnt--;
        if (m_cnt <= 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memf(m_addr);
          m_pend = 0;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        m_pend = 1;
        m_cnt  = m_lat;
        m_addr = imem_addr;
        addr_q.push_back(imem_addr);
        exp_q.push_back({imem_addr, memf(imem_addr)});
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      wrv = 1'b0;
      w_seen = 0;
      waddr_q.delete();
    end else begin
      wrv = w_seen;
      w_seen = wv;
      if (wv) waddr_q.push_back(wa);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    obs_q.delete(); exp_d.delete(); addr_q.delete();
  endtask

  task automatic wait_obs(input int n, output bit to);
    int c = 0;
    to = 0;
    while (obs_q.size() < n) begin
      @(posedge clk);
      c++;
      if (c > 200) begin to = 1; break; end
    end
    #1;
  endtask

  task automatic wait_fire(output bit to);
    int c = 0;
    to = 0;
    @(negedge clk);
    while (!(imem_req_valid && imem_req_ready)) begin
      @(negedge clk);
      c++;
      if (c > 50) begin to = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_ready = 1'b1; imem_req_ready = 1'b1; m_lat = 1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({imem_req_valid, instr_valid, imem_addr, instr, instr_pc} !== 98'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rv=%b iv=%b addr=%h instr=%h pc=%h, want all 0",
               imem_req_valid, instr_valid, imem_addr, instr, instr_pc);
    end
    rst = 1'b0;
    obs_q.delete(); exp_d.delete(); addr_q.delete();
    #1;
    n_cmp++;
    if (imem_addr !== 32'h0 || imem_req_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: got addr=%h rv=%b, want 00000000 1", imem_addr, imem_req_valid);
    end
  endtask

  task automatic test_basic();
    bit to;
    wait_obs(3, to);
    n_cmp++;
    if (to) begin
      n_bad++; $display("FAIL basic_timeout: got %0d words, want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (addr_q[i] !== 32'(i * 4)) begin
          n_bad++; $display("FAIL basic_addr%0d: got %h, want %h", i, addr_q[i], 32'(i * 4));
        end
        n_cmp++;
        if (obs_q[i] !== {32'(i * 4), memf(32'(i * 4))} || obs_q[i] !== exp_d[i]) begin
          n_bad++; $display("FAIL basic_word%0d: got %h, want %h", i, obs_q[i], {32'(i * 4), memf(32'(i * 4))});
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    instr_ready = 1'b0; m_lat = 1;
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (addr_q.size() !== 2 || imem_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_fill: got %0d reqs rv=%b, want 2 reqs rv=0", addr_q.size(), imem_req_valid);
    end
    n_cmp++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== memf(32'h0)) begin
      n_bad++; $display("FAIL bp_head: got v=%b pc=%h d=%h, want 1 0 %h", instr_valid, instr_pc, instr, memf(32'h0));
    end
    instr_ready = 1'b1;
    wait_obs(5, to);
    n_cmp++;
    if (to) begin
      n_bad++; $display("FAIL bp_timeout: got %0d words, want 5", obs_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (obs_q[i] !== {32'(i * 4), memf(32'(i * 4))} || obs_q[i] !== exp_d[i]) begin
          n_bad++; $display("FAIL bp_drain%0d: got %h, want %h", i, obs_q[i], {32'(i * 4), memf(32'(i * 4))});
        end
      end
    end
  endtask

  task automatic test_redirect_wait();
    bit to;
    int idx;
    instr_ready = 1'b1; m_lat = 3;
    do_reset();
    wait_fire(to);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    obs_q.delete(); exp_d.delete();
    idx = addr_q.size();
    wait_obs(2, to);
    n_cmp++;
    if (to) begin
      n_bad++; $display("FAIL rw_timeout: got %0d words, want 2", obs_q.size());
    end else begin
      n_cmp++;
      if (addr_q[idx] !== 32'h100) begin
        n_bad++; $display("FAIL rw_addr: got %h, want 00000100", addr_q[idx]);
      end
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs_q[i] !== {32'h100 + 32'(i * 4), memf(32'h100 + 32'(i * 4))} || obs_q[i] !== exp_d[i]) begin
          n_bad++; $display("FAIL rw_word%0d: got %h, want %h", i, obs_q[i], {32'h100 + 32'(i * 4), memf(32'h100 + 32'(i * 4))});
        end
      end
    end
  endtask

  task automatic test_redirect_rsp();
    bit to;
    int idx;
    instr_ready = 1'b1; m_lat = 2;
    do_reset();
    wait_fire(to);
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL rr_next: got rv=%b addr=%h iv=%b, want 1 00000200 0", imem_req_valid, imem_addr, instr_valid);
    end
    obs_q.delete(); exp_d.delete();
    idx = addr_q.size();
    wait_obs(1, to);
    n_cmp++;
    if (to || addr_q[idx] !== 32'h200 || obs_q[0] !== {32'h200, memf(32'h200)} || obs_q[0] !== exp_d[0]) begin
      n_bad++; $display("FAIL rr_first: got to=%b word=%h, want %h", to, to ? 64'h0 : obs_q[0], {32'h200, memf(32'h200)});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if (waddr_q.size() < 3) begin
      n_bad++; $display("FAIL wrap_count: got %0d reqs, want >=3", waddr_q.size());
    end else begin
      n_cmp++;
      if (waddr_q[0] !== 32'hFFFF_FFFC || waddr_q[1] !== 32'h0 || waddr_q[2] !== 32'h4) begin
        n_bad++; $display("FAIL wrap_addr: got %h %h %h, want fffffffc 00000000 00000004", waddr_q[0], waddr_q[1], waddr_q[2]);
      end
    end
  endtask

`ifdef IF_ALIGN_CHECK_EN
  task automatic test_misalign();
    bit to;
    int idx;
    instr_ready = 1'b1; m_lat = 1;
    do_reset();
    repeat (5) @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    idx = addr_q.size();
    n_cmp++;
    if (fetch_misaligned !== 1'b1 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL mis_set: got flag=%b iv=%b, want 1 0", fetch_misaligned, instr_valid);
    end
    repeat (8) @(posedge clk); #1;
    n_cmp++;
    if (addr_q.size() !== idx || imem_req_valid !== 1'b0 || fetch_misaligned !== 1'b1) begin
      n_bad++; $display("FAIL mis_hold: got %0d new reqs rv=%b flag=%b, want 0 0 1", addr_q.size() - idx, imem_req_valid, fetch_misaligned);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h104;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    n_cmp++;
    if (fetch_misaligned !== 1'b0) begin
      n_bad++; $display("FAIL mis_clear: got %b, want 0", fetch_misaligned);
    end
    obs_q.delete(); exp_d.delete();
    idx = addr_q.size();
    wait_obs(1, to);
    n_cmp++;
    if (to || addr_q[idx] !== 32'h104 || obs_q[0] !== {32'h104, memf(32'h104)}) begin
      n_bad++; $display("FAIL mis_resume: got to=%b word=%h, want %h", to, to ? 64'h0 : obs_q[0], {32'h104, memf(32'h104)});
    end
  endtask
`endif

  initial begin
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
`ifdef IF_ALIGN_CHECK_EN
    test_misalign();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
